// File: rtl/multicycle_adder.sv
// Multicycle ripple adder: adds C_CHUNK bits per cycle over N = C_WIDTH/C_CHUNK cycles.
// Valid/ready on both sides, with a three-state IDLE/BUSY/DONE controller.
module multicycle_adder #(
  parameter int C_WIDTH = 16,
  parameter int C_CHUNK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH:0]   y,
  output logic               busy
);

  localparam int N  = C_WIDTH / C_CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [C_WIDTH-1:0] a_reg, b_reg;
  logic               carry_reg;
  logic [IW-1:0]      idx_reg;
  logic [C_WIDTH:0]   y_reg;

  logic               accept;
  logic               step;
  logic               last;
  logic [C_CHUNK-1:0] a_cur, b_cur;
  logic [C_CHUNK:0]   chunk_sum;

  assign accept = in_ready && in_valid;
  assign step   = busy;
  assign last   = (idx_reg == LAST_IDX);
  assign y      = y_reg;

  // Chunk selection as a compare-and-mux so N need not be a power of two.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IW'(i)) begin
        a_cur = a_reg[i*C_CHUNK +: C_CHUNK];
        b_cur = b_reg[i*C_CHUNK +: C_CHUNK];
      end
    end
  end

  assign chunk_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{C_CHUNK{1'b0}}, carry_reg};

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        idx_reg   <= '0;
        y_reg     <= '0;
      end else if (step) begin
        carry_reg <= chunk_sum[C_CHUNK];
        idx_reg   <= idx_reg + IW'(1);
        for (int i = 0; i < N; i++) begin
          if (idx_reg == IW'(i)) y_reg[i*C_CHUNK +: C_CHUNK] <= chunk_sum[C_CHUNK-1:0];
        end
        // The top chunk's carry-out becomes the sum's MSB.
        if (last) y_reg[C_WIDTH] <= chunk_sum[C_CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder in three configurations: 16/4, 4/1 (exhaustive) and 8/8.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 16-bit, 4-bit chunks
  logic        v16 = 1'b0, r16, cin16 = 1'b0, ov16, ordy16 = 1'b0, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [16:0] y16;
  // 4-bit, 1-bit chunks
  logic        v4 = 1'b0, r4, cin4 = 1'b0, ov4, ordy4 = 1'b0, busy4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [4:0]  y4;
  // 8-bit, single chunk
  logic        v8 = 1'b0, r8, cin8 = 1'b0, ov8, ordy8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [8:0]  y8;

  multicycle_adder #(.C_WIDTH(16), .C_CHUNK(4)) u16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(ordy16), .y(y16), .busy(busy16)
  );
  multicycle_adder #(.C_WIDTH(4), .C_CHUNK(1)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(ordy4), .y(y4), .busy(busy4)
  );
  multicycle_adder #(.C_WIDTH(8), .C_CHUNK(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(ordy8), .y(y8), .busy(busy8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set on u16 and advance until out_valid (bounded).
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       output int lat, output int busy_cyc);
    a16 = av; b16 = bv; cin16 = cv; v16 = 1'b1;
    step();
    v16 = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!ov16 && lat < 40) begin
      if (busy16) busy_cyc++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    v16 = 1'b1; v4 = 1'b1; v8 = 1'b1;
    step();
    checks++;
    if (r16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || y16 !== 17'h0) begin
      failures++;
      $display("FAIL reset16 rdy=%b ov=%b busy=%b y=%h, want rdy=1 ov=0 busy=0 y=00000", r16, ov16, busy16, y16);
    end
    checks++;
    if (r4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0 || y4 !== 5'h0 ||
        r8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 9'h0) begin
      failures++;
      $display("FAIL reset4_8 r4=%b ov4=%b b4=%b y4=%h r8=%b ov8=%b b8=%b y8=%h, want idle zeros",
               r4, ov4, busy4, y4, r8, ov8, busy8, y8);
    end
    step();
    checks++;
    if (busy16 !== 1'b0 || busy4 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept busy16=%b busy4=%b busy8=%b, want 0", busy16, busy4, busy8);
    end
    v16 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    reset = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_carry_chain();
    int lat, bc;
    ordy16 = 1'b1; // ignored until DONE
    run16(16'hFFFF, 16'h0001, 1'b0, lat, bc);
    $display("txn carry_chain a=ffff b=0001 cin=0 y=%h lat=%0d busy=%0d", y16, lat, bc);
    checks++;
    if (y16 !== 17'h10000) begin
      failures++;
      $display("FAIL carry_chain_y got %h want 10000", y16);
    end
    checks++;
    if (lat !== 4 || bc !== 4) begin
      failures++;
      $display("FAIL carry_chain_latency lat=%0d busy=%0d want 4 4", lat, bc);
    end
    checks++;
    if (r16 !== 1'b0) begin
      failures++;
      $display("FAIL carry_chain_done_ready got %b want 0", r16);
    end
    step();
    checks++;
    if (r16 !== 1'b1 || ov16 !== 1'b0 || y16 !== 17'h10000) begin
      failures++;
      $display("FAIL carry_chain_release rdy=%b ov=%b y=%h want 1 0 10000", r16, ov16, y16);
    end
    ordy16 = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bc;
    int bad = 0;
    run16(16'h1234, 16'h4321, 1'b1, lat, bc);
    $display("txn backpressure a=1234 b=4321 cin=1 y=%h lat=%0d", y16, lat);
    checks++;
    if (y16 !== 17'h05556 || lat !== 4) begin
      failures++;
      $display("FAIL bp_result y=%h lat=%0d want 05556 4", y16, lat);
    end
    for (int k = 0; k < 10; k++) begin
      v16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555;
      step();
      if (y16 !== 17'h05556 || ov16 !== 1'b1 || r16 !== 1'b0) bad++;
    end
    v16 = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d want 0 (y=%h ov=%b rdy=%b)", bad, y16, ov16, r16);
    end
    ordy16 = 1'b1;
    step();
    ordy16 = 1'b0;
    checks++;
    if (r16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || y16 !== 17'h05556) begin
      failures++;
      $display("FAIL bp_release rdy=%b ov=%b busy=%b y=%h want 1 0 0 05556", r16, ov16, busy16, y16);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    int seen_ov = 0;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b0; v16 = 1'b1;
    step();
    v16 = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (r16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || y16 !== 17'h0) begin
      failures++;
      $display("FAIL abort_state rdy=%b ov=%b busy=%b y=%h want 1 0 0 00000", r16, ov16, busy16, y16);
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ov16 !== 1'b0 || busy16 !== 1'b0) seen_ov++;
    end
    checks++;
    if (seen_ov != 0) begin
      failures++;
      $display("FAIL abort_quiet active_cycles=%0d want 0", seen_ov);
    end
    run16(16'h0001, 16'h0002, 1'b0, lat, bc);
    $display("txn after_abort a=0001 b=0002 cin=0 y=%h lat=%0d", y16, lat);
    checks++;
    if (y16 !== 17'h00003 || lat !== 4) begin
      failures++;
      $display("FAIL abort_next y=%h lat=%0d want 00003 4", y16, lat);
    end
    ordy16 = 1'b1;
    step();
    ordy16 = 1'b0;
  endtask

  task automatic test_operand_change();
    int lat = 0;
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; v16 = 1'b1;
    step();
    while (!ov16 && lat < 40) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); v16 = 1'($urandom);
      step();
      lat++;
    end
    v16 = 1'b0;
    $display("txn operand_change a=00ff b=0001 cin=0 y=%h lat=%0d", y16, lat);
    checks++;
    if (y16 !== 17'h00100 || lat !== 4) begin
      failures++;
      $display("FAIL operand_change y=%h lat=%0d want 00100 4", y16, lat);
    end
    ordy16 = 1'b1;
    step();
    ordy16 = 1'b0;
  endtask

  task automatic test_exhaustive_c1();
    int lat;
    logic [4:0] exp;
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int z = 0; z < 16; z++) begin
          a4 = 4'(x); b4 = 4'(z); cin4 = 1'(c); v4 = 1'b1;
          exp = 5'(x + z + c);
          step();
          v4 = 1'b0;
          lat = 0;
          while (!ov4 && lat < 20) begin
            step();
            lat++;
          end
          $display("txn w4 a=%h b=%h cin=%0d y=%h lat=%0d", a4, b4, c, y4, lat);
          checks++;
          if (y4 !== exp || lat !== 4) begin
            failures++;
            $display("FAIL w4_sum a=%h b=%h cin=%0d y=%h lat=%0d want %h 4", a4, b4, c, y4, lat, exp);
          end
          ordy4 = 1'b1;
          step();
          ordy4 = 1'b0;
        end
      end
    end
  endtask

  task automatic test_single_chunk();
    int lat = 0;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; v8 = 1'b1;
    step();
    v8 = 1'b0;
    while (!ov8 && lat < 20) begin
      step();
      lat++;
    end
    $display("txn w8 a=80 b=80 cin=1 y=%h lat=%0d", y8, lat);
    checks++;
    if (y8 !== 9'h101 || lat !== 1) begin
      failures++;
      $display("FAIL w8_single y=%h lat=%0d want 101 1", y8, lat);
    end
    ordy8 = 1'b1;
    step();
    ordy8 = 1'b0;
    checks++;
    if (r8 !== 1'b1 || ov8 !== 1'b0 || y8 !== 9'h101) begin
      failures++;
      $display("FAIL w8_release rdy=%b ov=%b y=%h want 1 0 101", r8, ov8, y8);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_backpressure();
    test_reset_abort();
    test_operand_change();
    test_exhaustive_c1();
    test_single_chunk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter C_WIDTH, default 16, operand width in bits (>=1).
REQ-002 SHALL have parameter C_CHUNK, default 4, bits added per cycle; C_WIDTH SHALL be an integer multiple of C_CHUNK; N = C_WIDTH/C_CHUNK.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set a/b/cin is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SHALL have port a  input  C_WIDTH  unsigned operand A.
REQ-008 SHALL have port b  input  C_WIDTH  unsigned operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  y holds a completed sum.
REQ-011 SHALL have port out_ready  input  1  consumer takes y this cycle.
REQ-012 SHALL have port y  output  C_WIDTH+1  sum; y[C_WIDTH] is carry-out.
REQ-013 SHALL have port busy  output  1  high while in state BUSY.

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in BUSY.
REQ-016 Accept SHALL occur on an edge where in_valid=1 and in_ready=1: a, b, cin latched into internal registers, chunk index cleared to 0, carry register loaded with cin, y cleared to 0, next state BUSY.
REQ-017 In IDLE with in_valid=0, state and all registers SHALL hold.
REQ-018 Each BUSY cycle SHALL compute a[i*C_CHUNK +: C_CHUNK] + b[same] + carry (latched copies), write the low C_CHUNK bits to y[i*C_CHUNK +: C_CHUNK], store the chunk carry-out into the carry register, increment i.
REQ-019 On the BUSY cycle with i = N-1, SHALL additionally write the final carry into y[C_WIDTH] and move to DONE.
REQ-020 Latency: out_valid SHALL rise exactly N clock edges after the accept edge (N=1 when C_CHUNK=C_WIDTH).
REQ-021 Final y SHALL equal (a + b + cin) mod 2^(C_WIDTH+1) of the accepted operands; no overflow possible.
REQ-022 Changes on a, b, cin, in_valid after accept SHALL NOT affect the result in flight.
REQ-023 In DONE, y and out_valid SHALL hold stable while out_ready=0 (unbounded backpressure).
REQ-024 In DONE with out_ready=1, SHALL return to IDLE on that edge; y SHALL keep its value in IDLE until the next accept.
REQ-025 No operand SHALL be accepted in the same cycle a result is delivered (in_ready=0 in DONE); minimum throughput one operation per N+2 cycles.
REQ-026 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.

Reset
REQ-027 On an edge with reset=0, SHALL enter IDLE and clear y, internal operand registers, carry register and chunk index to 0, regardless of state.
REQ-028 Reset outputs: in_ready=1, out_valid=0, busy=0, y=0; these values visible from the first edge with reset=0.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no out_valid pulse; the partial result SHALL be discarded.
REQ-030 in_valid high during reset SHALL NOT be accepted; first accept possible on the first edge with reset=1.

Verification
REQ-031 C_WIDTH=16,C_CHUNK=4: a=0xFFFF,b=0x0001,cin=0 -> busy 4 cycles, out_valid 4 edges after accept, y=0x10000.
REQ-032 C_WIDTH=16,C_CHUNK=4: a=0x1234,b=0x4321,cin=1, out_ready held 0 for 10 cycles -> y=0x05556 stable, out_valid held, in_ready=0 throughout; release -> IDLE next edge.
REQ-033 Reset=0 applied on 2nd BUSY cycle of a=0xFFFF,b=0xFFFF -> next edge IDLE, y=0, no out_valid; subsequent a=1,b=2,cin=0 -> y=0x00003.
REQ-034 a/b changed every cycle during BUSY after accepting a=0x00FF,b=0x0001 -> y=0x00100 (latched operands used).
REQ-035 C_WIDTH=4,C_CHUNK=1 exhaustive sweep of all 256 a/b pairs with cin=0 and cin=1 -> every y equals a+b+cin, latency 4 each.
REQ-036 C_WIDTH=8,C_CHUNK=8: a=0x80,b=0x80,cin=1 -> out_valid 1 edge after accept, y=0x101.
